// File: rtl/fifo_word_serializer.sv
// Pops IN_WIDTH-bit words from an upstream FIFO and emits them as RATIO OUT_WIDTH-bit beats
// over a valid/ready handshake, back-to-back across words with no bubble cycles.
module fifo_word_serializer #(
   parameter int unsigned IN_WIDTH  = 32,
   parameter int unsigned OUT_WIDTH = 8,
   parameter logic        MSB_FIRST = 1'b0,
   localparam int unsigned RATIO    = IN_WIDTH / OUT_WIDTH,
   localparam int unsigned CNT_W    = $clog2(RATIO)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 flush_i,
   input  logic [IN_WIDTH-1:0]  fifo_data_i,
   input  logic                 fifo_empty_i,
   output logic                 fifo_pop_o,
   output logic [OUT_WIDTH-1:0] data_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic                 last_o,
   output logic [CNT_W-1:0]     beat_idx_o,
   output logic                 busy_o
);

   if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_params
      $error("fifo_word_serializer: IN_WIDTH must be a multiple of OUT_WIDTH with RATIO >= 2");
   end

   localparam logic [0:0] StIdle  = 1'b0;
   localparam logic [0:0] StShift = 1'b1;

   localparam logic [CNT_W-1:0] LastIdx = CNT_W'(RATIO - 1);

   logic [0:0]          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IN_WIDTH-1:0] word_q, word_d;
   logic                handshake;
   logic [CNT_W-1:0]    slice_sel;
   logic [IN_WIDTH-1:0] word_shifted;

   always_comb begin
      valid_o    = (state_q == StShift);
      busy_o     = (state_q == StShift);
      last_o     = valid_o & (cnt_q == LastIdx);
      beat_idx_o = cnt_q;
      handshake  = valid_o & ready_i;
      // rst_ni gating keeps the pop strobe low while reset is held, even if the FIFO has data
      fifo_pop_o = rst_ni & ~fifo_empty_i & ~flush_i &
                   ((state_q == StIdle) | (handshake & last_o));
   end

   always_comb begin
      slice_sel    = MSB_FIRST ? (LastIdx - cnt_q) : cnt_q;
      word_shifted = word_q >> (32'(slice_sel) * OUT_WIDTH);
      data_o       = word_shifted[OUT_WIDTH-1:0];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      if (flush_i) begin
         state_d = StIdle;
         cnt_d   = '0;
         word_d  = '0;
      end else if (fifo_pop_o) begin
         state_d = StShift;
         cnt_d   = '0;
         word_d  = fifo_data_i;
      end else if (handshake) begin
         if (last_o) begin
            state_d = StIdle;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
      end
   end

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Bench for fifo_word_serializer: LSB-first and MSB-first instances share one stimulus stream
// and are checked every cycle against a queue-based word/beat model.
module tb_fifo_word_serializer;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        flush_i = 1'b0;
   logic [31:0] fifo_data_i = '0;
   logic        fifo_empty_i = 1'b1;
   logic        ready_i = 1'b0;

   logic       pop0, pop1, valid0, valid1, last0, last1, busy0, busy1;
   logic [7:0] data0, data1;
   logic [1:0] idx0, idx1;

   always #5 clk_i = ~clk_i;

   fifo_word_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .fifo_data_i(fifo_data_i),
      .fifo_empty_i(fifo_empty_i), .fifo_pop_o(pop0), .data_o(data0), .valid_o(valid0),
      .ready_i(ready_i), .last_o(last0), .beat_idx_o(idx0), .busy_o(busy0)
   );

   fifo_word_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .fifo_data_i(fifo_data_i),
      .fifo_empty_i(fifo_empty_i), .fifo_pop_o(pop1), .data_o(data1), .valid_o(valid1),
      .ready_i(ready_i), .last_o(last1), .beat_idx_o(idx1), .busy_o(busy1)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Model: upstream FIFO contents plus the word currently being emitted
   logic [31:0] q[$];
   bit          m_have = 1'b0;
   logic [31:0] m_word = '0;
   int          m_idx  = 0;

   logic [7:0] lsb_exp[4] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
   logic [7:0] msb_exp[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

   task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input bit r, input bit f);
      @(negedge clk_i);
      ready_i      = r;
      flush_i      = f;
      fifo_empty_i = (q.size() == 0);
      fifo_data_i  = (q.size() == 0) ? $urandom : q[0];
      #1;
   endtask

   // Compare both instances against the model for the current cycle, then advance the model
   task automatic chk_model();
      bit         e_last, e_pop;
      logic [7:0] e_d0, e_d1;
      bit         ok;
      e_last = m_have && (m_idx == 3);
      e_pop  = (q.size() != 0) && !flush_i && (!m_have || (ready_i && e_last));
      e_d0   = 8'((m_word >> (8 * m_idx)) & 32'hFF);
      e_d1   = 8'((m_word >> (8 * (3 - m_idx))) & 32'hFF);
      ok = (pop0 === e_pop) && (pop1 === e_pop) && (valid0 === m_have) && (valid1 === m_have) &&
           (busy0 === m_have) && (busy1 === m_have) && (last0 === e_last) &&
           (last1 === e_last) && (idx0 === 2'(m_idx)) && (idx1 === 2'(m_idx));
      if (m_have) ok = ok && (data0 === e_d0) && (data1 === e_d1);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL model t=%0t: got pop=%b/%b valid=%b/%b busy=%b/%b last=%b/%b idx=%0d/%0d data=%h/%h required pop=%b valid=%b last=%b idx=%0d data=%h/%h",
                  $time, pop0, pop1, valid0, valid1, busy0, busy1, last0, last1, idx0, idx1,
                  data0, data1, e_pop, m_have, e_last, m_idx, e_d0, e_d1);
      end
      if (flush_i) begin
         m_have = 1'b0;
         m_idx  = 0;
      end else if (e_pop) begin
         m_word = q.pop_front();
         m_have = 1'b1;
         m_idx  = 0;
      end else if (m_have && ready_i) begin
         if (e_last) begin
            m_have = 1'b0;
            m_idx  = 0;
         end else begin
            m_idx++;
         end
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((m_have || q.size() != 0) && n < 100) begin
         cyc(1'b1, 1'b0);
         chk_model();
         n++;
      end
      lit("drain_timeout", 32'(m_have || q.size() != 0), 32'd0);
   endtask

   initial begin
      // Reset state
      #2;
      lit("rst_valid", 32'(valid0), 32'd0);
      lit("rst_busy", 32'(busy0), 32'd0);
      lit("rst_data", 32'(data0), 32'd0);
      lit("rst_pop", 32'(pop0), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Single word, both slice orders
      q.push_back(32'hAABBCCDD);
      for (int c = 0; c < 6; c++) begin
         cyc(1'b1, 1'b0);
         if (c == 0) begin
            lit("w1_pop_c0", 32'(pop0), 32'd1);
            lit("w1_valid_c0", 32'(valid0), 32'd0);
         end else if (c <= 4) begin
            lit("w1_valid", 32'(valid0), 32'd1);
            lit("w1_lsb_data", 32'(data0), 32'(lsb_exp[c-1]));
            lit("w1_msb_data", 32'(data1), 32'(msb_exp[c-1]));
            lit("w1_last", 32'(last0), 32'(c == 4));
         end else begin
            lit("w1_idle_valid", 32'(valid0), 32'd0);
            lit("w1_idle_busy", 32'(busy0), 32'd0);
         end
         chk_model();
      end

      // Three words back to back
      q.push_back(32'h11223344);
      q.push_back(32'h55667788);
      q.push_back(32'h99AABBCC);
      for (int c = 0; c < 13; c++) begin
         cyc(1'b1, 1'b0);
         lit("b2b_pop", 32'(pop0), 32'((c == 0) || (c == 4) || (c == 8)));
         if (c >= 1) lit("b2b_valid", 32'(valid0), 32'd1);
         chk_model();
      end
      drain();

      // Backpressure during beat 2
      q.push_back(32'h12345678);
      q.push_back(32'h9ABCDEF0);
      for (int c = 0; c < 6; c++) begin
         cyc(!(c >= 3), 1'b0);
         if (c >= 3) begin
            lit("stall_idx", 32'(idx0), 32'd2);
            lit("stall_data", 32'(data0), 32'h34);
            lit("stall_pop", 32'(pop0), 32'd0);
         end
         chk_model();
      end
      drain();

      // Flush during beat 1 with more data waiting
      q.push_back(32'hA0A1A2A3);
      q.push_back(32'hB0B1B2B3);
      cyc(1'b1, 1'b0); chk_model();
      cyc(1'b1, 1'b0); chk_model();
      cyc(1'b1, 1'b1);
      lit("flush_idx", 32'(idx0), 32'd1);
      lit("flush_pop", 32'(pop0), 32'd0);
      chk_model();
      cyc(1'b1, 1'b0);
      lit("flush_valid_next", 32'(valid0), 32'd0);
      lit("flush_repop", 32'(pop0), 32'd1);
      chk_model();
      cyc(1'b1, 1'b0);
      lit("flush_new_idx", 32'(idx0), 32'd0);
      lit("flush_new_data", 32'(data0), 32'hB3);
      chk_model();
      drain();

      // Reset asserted during beat 3
      q.push_back(32'hC0C1C2C3);
      q.push_back(32'hD0D1D2D3);
      for (int c = 0; c < 4; c++) begin
         cyc(1'b1, 1'b0);
         chk_model();
      end
      cyc(1'b0, 1'b0);
      lit("prerst_idx", 32'(idx0), 32'd3);
      chk_model();
      rst_ni = 1'b0;
      #1;
      lit("mrst_valid", 32'(valid0), 32'd0);
      lit("mrst_last", 32'(last0), 32'd0);
      lit("mrst_busy", 32'(busy0), 32'd0);
      lit("mrst_idx", 32'(idx0), 32'd0);
      lit("mrst_data", 32'(data0), 32'd0);
      lit("mrst_pop", 32'(pop0), 32'd0);
      lit("mrst_data_msb", 32'(data1), 32'd0);
      m_have = 1'b0;
      m_idx  = 0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      chk_model();
      cyc(1'b1, 1'b0);
      lit("postrst_idx", 32'(idx0), 32'd0);
      lit("postrst_data", 32'(data0), 32'hD3);
      chk_model();
      drain();

      // Randomized traffic
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 2) == 0 && q.size() < 4) q.push_back($urandom);
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
         chk_model();
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
